// File: rtl/vortex_video_scan_if.sv
// vortex_video_scan_if: video RAM fetch port between the scan generator and the RAM arbiter
//   Ram_Addr  registered bitmap fetch address (scan -> RAM)
//   Vid_Req   scan requests the RAM port       (scan -> arbiter)
//   Vid_Gnt   arbiter grant of the RAM port    (arbiter -> scan)
//   Ram_out   read data, one Clock after Ram_Addr is stable (RAM -> scan)
interface vortex_video_scan_if;
  logic [15:0] Ram_Addr;
  logic        Vid_Req;
  logic        Vid_Gnt;
  logic [7:0]  Ram_out;
  modport master (output Ram_Addr, Vid_Req, input Vid_Gnt, Ram_out);
  modport slave  (input Ram_Addr, Vid_Req, output Vid_Gnt, Ram_out);
endinterface

// File: rtl/vortex_video_scan.sv
// vortex_video_scan: monochrome raster timing, bitmap fetch and pixel shifter
//   Clock, Rst_n      system clock, asynchronous active-low reset
//   Pix_Ce            pixel clock enable
//   ram               fetch port (Ram_Addr, Vid_Req out; Vid_Gnt, Ram_out in)
//   Pixel             blank-gated pixel, bit 0 of each byte is leftmost
//   HBlank..VSync     active-high timing strobes
//   Int_Mid, Int_Vbl  one-Clock pulses as VCnt enters 96 / 224
//   HCnt, VCnt        beam position
module vortex_video_scan #(
  parameter logic [15:0] VRAM_BASE = 16'h2400,
  parameter int          H_TOTAL   = 320,
  parameter int          V_TOTAL   = 262
) (
  input  logic                       Clock,
  input  logic                       Rst_n,
  input  logic                       Pix_Ce,
  vortex_video_scan_if.master        ram,
  output logic                       Pixel,
  output logic                       HBlank,
  output logic                       VBlank,
  output logic                       HSync,
  output logic                       VSync,
  output logic                       Int_Mid,
  output logic                       Int_Vbl,
  output logic [8:0]                 HCnt,
  output logic [8:0]                 VCnt
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t      state_q, state_d;
  logic [8:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] addr_q, addr_d;
  logic        gnt_q, gnt_d, int_mid_q, int_mid_d, int_vbl_q, int_vbl_d;
  logic        h_wrap, slot_ok;
  logic [8:0]  v_inc, h_ahead, h_grp, line;
  logic [15:0] fetch_addr;
  // The slot at HCnt[2:0]==5 fetches the group starting three pixels later,
  // so the slot at the last-but-two pixel of a line prefetches group 0 of the next line.
  always_comb begin
    h_wrap     = hcnt_q == 9'(H_TOTAL - 1);
    v_inc      = (vcnt_q == 9'(V_TOTAL - 1)) ? '0 : vcnt_q + 9'd1;
    h_ahead    = hcnt_q + 9'd3;
    h_grp      = (h_ahead >= 9'(H_TOTAL)) ? h_ahead - 9'(H_TOTAL) : h_ahead;
    line       = (hcnt_q == 9'(H_TOTAL - 3)) ? v_inc : vcnt_q;
    slot_ok    = (h_grp < 9'd256) && (line < 9'd224);
    fetch_addr = VRAM_BASE + {2'b0, line, 5'b0} + 16'(h_grp >> 3);
  end
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    int_mid_d = 1'b0;
    int_vbl_d = 1'b0;
    // grant history is tracked every Clock: a byte is good only if granted on both edges
    gnt_d     = (state_q == REQ) && ram.Vid_Gnt;
    if (Pix_Ce) begin
      hcnt_d    = h_wrap ? '0 : hcnt_q + 9'd1;
      vcnt_d    = h_wrap ? v_inc : vcnt_q;
      int_mid_d = h_wrap && (v_inc == 9'd96);
      int_vbl_d = h_wrap && (v_inc == 9'd224);
      if (hcnt_q[2:0] == 3'd5 && slot_ok) begin
        state_d = REQ;
        addr_d  = fetch_addr;
      end
      if (hcnt_q[2:0] == 3'd7) begin
        state_d = IDLE;
        sh_d    = (state_q == REQ && ram.Vid_Gnt && gnt_q) ? ram.Ram_out : 8'h00;
      end else begin
        sh_d    = {1'b0, sh_q[7:1]};
      end
    end
  end
  always_ff @(posedge Clock or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      sh_q      <= '0;
      addr_q    <= VRAM_BASE;
      gnt_q     <= 1'b0;
      int_mid_q <= 1'b0;
      int_vbl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      gnt_q     <= gnt_d;
      int_mid_q <= int_mid_d;
      int_vbl_q <= int_vbl_d;
    end
  end
  assign ram.Ram_Addr = addr_q;
  assign ram.Vid_Req  = state_q == REQ;
  assign HCnt         = hcnt_q;
  assign VCnt         = vcnt_q;
  assign HBlank       = hcnt_q >= 9'd256;
  assign VBlank       = vcnt_q >= 9'd224;
  assign HSync        = (hcnt_q >= 9'd272) && (hcnt_q <= 9'd303);
  assign VSync        = (vcnt_q >= 9'd236) && (vcnt_q <= 9'd239);
  assign Pixel        = sh_q[0] & ~(HBlank | VBlank);
  assign Int_Mid      = int_mid_q;
  assign Int_Vbl      = int_vbl_q;
endmodule

// File: tb/tb_vortex_video_scan.sv
// tb_vortex_video_scan: directed self-checking bench for vortex_video_scan
module tb_vortex_video_scan;
  logic       Clock = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Pix_Ce = 1'b0;
  logic       Pixel, HBlank, VBlank, HSync, VSync, Int_Mid, Int_Vbl;
  logic [8:0] HCnt, VCnt;
  logic [7:0] mem [0:65535];
  int         checks = 0;
  int         failures = 0;
  vortex_video_scan_if ram_if();
  vortex_video_scan dut (
    .Clock(Clock), .Rst_n(Rst_n), .Pix_Ce(Pix_Ce), .ram(ram_if),
    .Pixel(Pixel), .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
    .Int_Mid(Int_Mid), .Int_Vbl(Int_Vbl), .HCnt(HCnt), .VCnt(VCnt)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) ram_if.Ram_out <= mem[ram_if.Ram_Addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_hcnt"}, 32'(HCnt), 32'd0);
    chk({tag, "_vcnt"}, 32'(VCnt), 32'd0);
    chk({tag, "_addr"}, 32'(ram_if.Ram_Addr), 32'h2400);
    chk({tag, "_req"}, 32'(ram_if.Vid_Req), 32'd0);
    chk({tag, "_pix"}, 32'(Pixel), 32'd0);
    chk({tag, "_flags"}, 32'({HBlank, VBlank, HSync, VSync, Int_Mid, Int_Vbl}), 32'd0);
  endtask
  initial begin
    int hx, vy, fr, t1, t2, h_first;
    int pos_err, req_bad, int_bad, mid_n, vbl_n;
    int l0_ones, f2_ones, ones_f1, g5_ones, g6_ones, l11_ones;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2400] = 8'h01;
    mem[16'h3fff] = 8'h80;
    mem[16'h2545] = 8'hff;
    mem[16'h2546] = 8'hff;
    mem[16'h2565] = 8'hff;
    ram_if.Vid_Gnt = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    Rst_n  = 1'b1;
    Pix_Ce = 1'b1;
    repeat (790) tick();
    chk("pre_rst_hcnt", 32'(HCnt), 32'd150);
    chk("pre_rst_vcnt", 32'(VCnt), 32'd2);
    chk("pre_rst_req", 32'(ram_if.Vid_Req), 32'd1);
    chk("pre_rst_addr", 32'(ram_if.Ram_Addr), 32'h2453);
    #2 Rst_n = 1'b0;
    #1 chk_reset("async");
    tick();
    tick();
    Rst_n = 1'b1;
    t1 = -1;
    t2 = -1;
    h_first = -1;
    for (int c = 0; c < 4000; c++) begin
      Pix_Ce = (c % 4) == 0;
      tick();
      if (c == 0) h_first = int'(HCnt);
      if (VCnt == 9'd1 && t1 < 0) t1 = c;
      if (VCnt == 9'd2) begin
        t2 = c;
        break;
      end
    end
    chk("first_ce", 32'(h_first), 32'd1);
    chk("line_clk", 32'(t2 - t1), 32'd1280);
    Pix_Ce = 1'b0;
    Rst_n  = 1'b0;
    tick();
    Rst_n  = 1'b1;
    Pix_Ce = 1'b1;
    {pos_err, req_bad, int_bad, mid_n, vbl_n} = '0;
    {l0_ones, f2_ones, ones_f1, g5_ones, g6_ones, l11_ones} = '0;
    for (int i = 0; i < 84160; i++) begin
      hx = i % 320;
      vy = (i / 320) % 262;
      fr = i / 83840;
      if (int'(HCnt) != hx || int'(VCnt) != vy) pos_err++;
      if (ram_if.Vid_Req && ((vy >= 224 && !(vy == 261 && hx >= 318)) || (hx >= 253 && hx <= 316))) req_bad++;
      if (Int_Mid) begin
        mid_n++;
        if (vy != 96 || hx != 0) int_bad++;
      end
      if (Int_Vbl) begin
        vbl_n++;
        if (vy != 224 || hx != 0) int_bad++;
      end
      if (fr == 0) ones_f1 += int'(Pixel);
      if (fr == 0 && vy == 0) l0_ones += int'(Pixel);
      if (fr == 1 && vy == 0) f2_ones += int'(Pixel);
      if (fr == 0 && vy == 10 && hx >= 40 && hx <= 47) g5_ones += int'(Pixel);
      if (fr == 0 && vy == 10 && hx >= 48 && hx <= 55) g6_ones += int'(Pixel);
      if (fr == 0 && vy == 11 && hx >= 40 && hx <= 47) l11_ones += int'(Pixel);
      if (fr == 1 && vy == 0 && hx == 0) chk("f2_px0", 32'(Pixel), 32'd1);
      if (fr == 0 && vy == 223 && hx == 246) chk("addr_3fff", 32'(ram_if.Ram_Addr), 32'h3fff);
      if (fr == 0 && vy == 223 && hx == 255) chk("px_3fff", 32'(Pixel), 32'd1);
      if (vy == 261 && hx == 318) begin
        chk("pre_addr", 32'(ram_if.Ram_Addr), 32'h2400);
        chk("pre_req", 32'(ram_if.Vid_Req), 32'd1);
      end
      if (fr == 0 && vy == 5 && (hx == 255 || hx == 256)) chk("hblank", 32'(HBlank), 32'(hx == 256));
      if (fr == 0 && vy == 5 && (hx == 271 || hx == 272 || hx == 303 || hx == 304))
        chk("hsync", 32'(HSync), 32'(hx == 272 || hx == 303));
      if (fr == 0 && hx == 0 && (vy == 223 || vy == 224 || vy == 235 || vy == 236 || vy == 239 || vy == 240))
        chk("vtiming", 32'({VBlank, VSync}), 32'({vy != 223, vy >= 236 && vy <= 239}));
      ram_if.Vid_Gnt = !(fr == 0 && ((vy == 10 && hx == 38) || (vy == 11 && hx == 39)));
      tick();
    end
    chk("beam_pos", 32'(pos_err), 32'd0);
    chk("req_window", 32'(req_bad), 32'd0);
    chk("int_where", 32'(int_bad), 32'd0);
    chk("int_mid_n", 32'(mid_n), 32'd1);
    chk("int_vbl_n", 32'(vbl_n), 32'd1);
    chk("f1_line0", 32'(l0_ones), 32'd0);
    chk("f2_line0", 32'(f2_ones), 32'd1);
    chk("gnt_miss_g5", 32'(g5_ones), 32'd0);
    chk("gnt_ok_g6", 32'(g6_ones), 32'd8);
    chk("gnt_miss_l11", 32'(l11_ones), 32'd0);
    chk("f1_ones", 32'(ones_f1), 32'd9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
